// File: rtl/mithril_modarith_ct_pkg.sv
// Shared definitions for the constant-time limb-serial add/sub engine.
//   - default operand width and limb size
//   - operation mode encoding (as driven on the 2-bit mode port)
//   - controller state encoding
package mithril_modarith_ct_pkg;

  localparam int unsigned DefaultWidth = 256;
  localparam int unsigned DefaultLimb  = 64;

  // Bit 0 selects subtraction on the main chain; bit 1 selects modular reduction.
  typedef enum logic [1:0] {
    ModeAdd    = 2'b00,
    ModeSub    = 2'b01,
    ModeModadd = 2'b10,
    ModeModsub = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPass1 = 2'b01,
    StPass2 = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/mithril_modarith_ct_if.sv
// Request/response bundle for mithril_modarith_ct.
//   master: drives start/mode/operand_a/operand_b/modulus, observes the outputs
//   slave : the engine; drives result/carry_out/done/error/busy
interface mithril_modarith_ct_if
  import mithril_modarith_ct_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             done;
  logic             error;
  logic             busy;

  modport master (
    output start, mode, operand_a, operand_b, modulus,
    input  result, carry_out, done, error, busy
  );

  modport slave (
    input  start, mode, operand_a, operand_b, modulus,
    output result, carry_out, done, error, busy
  );

endinterface

// File: rtl/mithril_modarith_ct_limb_addsub.sv
// One limb of a ripple add/sub chain.
//   a_i, b_i : limb operands
//   cin_i    : carry-in (add) or borrow-in (sub)
//   sub_i    : 1 = a - b - cin, 0 = a + b + cin
//   sum_o    : limb result
//   cout_o   : carry-out (add) or borrow-out (sub)
module mithril_modarith_ct_limb_addsub #(
  parameter int unsigned LIMB = 64
) (
  input  logic [LIMB-1:0] a_i,
  input  logic [LIMB-1:0] b_i,
  input  logic            cin_i,
  input  logic            sub_i,
  output logic [LIMB-1:0] sum_o,
  output logic            cout_o
);

  logic [LIMB:0] add_ext;
  logic [LIMB:0] sub_ext;
  logic [LIMB:0] res_ext;

  // Both results are always formed and then muxed, so the path never depends on sub_i.
  // In the LIMB+1-bit difference the top bit is set exactly when the result went negative.
  always_comb begin
    add_ext = {1'b0, a_i} + {1'b0, b_i} + {{LIMB{1'b0}}, cin_i};
    sub_ext = {1'b0, a_i} - {1'b0, b_i} - {{LIMB{1'b0}}, cin_i};
    res_ext = sub_i ? sub_ext : add_ext;
    sum_o   = res_ext[LIMB-1:0];
    cout_o  = res_ext[LIMB];
  end

endmodule

// File: rtl/mithril_modarith_ct.sv
// Constant-time limb-serial add/sub engine (ADD, SUB, MODADD, MODSUB).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of mithril_modarith_ct_if (start/mode/operands/modulus in,
//                result/carry_out/done/error/busy out)
// Two passes of NLIMB cycles each regardless of mode or data: pass 1 forms s = a +/- b
// plus the a-p and b-p range checks, pass 2 forms the correction t = s -/+ p. The final
// pick is a mux, and all operand/intermediate state is wiped on completion.
module mithril_modarith_ct
  import mithril_modarith_ct_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned LIMB  = DefaultLimb
) (
  input logic                   clk,
  input logic                   rst_n,
  mithril_modarith_ct_if.slave  bus
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned IdxW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NLIMB - 1);

  if (WIDTH % LIMB != 0) begin : g_width_check
    $error("mithril_modarith_ct: WIDTH must be a multiple of LIMB");
  end

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, s_q, t_q;
  logic [IdxW-1:0]  idx_q;
  logic             c1_q, c2_q, ba_q, bb_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q, done_q, error_q, busy_q;

  logic [31:0]      base;
  logic [LIMB-1:0]  a_limb, b_limb, p_limb, s_limb;
  logic [LIMB-1:0]  main_sum, corr_sum;
  logic             main_cout, corr_cout, ba_cout, bb_cout;
  logic [LIMB-1:0]  unused_a_diff, unused_b_diff;

  assign base   = 32'(idx_q) * LIMB;
  assign a_limb = a_q[base +: LIMB];
  assign b_limb = b_q[base +: LIMB];
  assign p_limb = p_q[base +: LIMB];
  assign s_limb = s_q[base +: LIMB];

  mithril_modarith_ct_limb_addsub #(.LIMB(LIMB)) u_main (
    .a_i    (a_limb),
    .b_i    (b_limb),
    .cin_i  (c1_q),
    .sub_i  (mode_q[0]),
    .sum_o  (main_sum),
    .cout_o (main_cout)
  );

  // MODSUB adds p back; every other mode (ADD/SUB results discarded) subtracts it.
  mithril_modarith_ct_limb_addsub #(.LIMB(LIMB)) u_corr (
    .a_i    (s_limb),
    .b_i    (p_limb),
    .cin_i  (c2_q),
    .sub_i  (mode_q != ModeModsub),
    .sum_o  (corr_sum),
    .cout_o (corr_cout)
  );

  mithril_modarith_ct_limb_addsub #(.LIMB(LIMB)) u_achk (
    .a_i    (a_limb),
    .b_i    (p_limb),
    .cin_i  (ba_q),
    .sub_i  (1'b1),
    .sum_o  (unused_a_diff),
    .cout_o (ba_cout)
  );

  mithril_modarith_ct_limb_addsub #(.LIMB(LIMB)) u_bchk (
    .a_i    (b_limb),
    .b_i    (p_limb),
    .cin_i  (bb_q),
    .sub_i  (1'b1),
    .sum_o  (unused_b_diff),
    .cout_o (bb_cout)
  );

  // Final selection, evaluated while in StDone. A clear final borrow on a-p or b-p
  // means the operand is not below the modulus.
  logic             mod_mode, take_t, err_sel;
  logic [WIDTH-1:0] res_sel;

  always_comb begin
    mod_mode = mode_q[1];
    err_sel  = mod_mode & ((p_q == '0) | ~ba_q | ~bb_q);
    unique case (mode_q)
      ModeModadd: take_t = c1_q | ~c2_q;
      ModeModsub: take_t = c1_q;
      default:    take_t = 1'b0;
    endcase
    res_sel = err_sel ? '0 : (take_t ? t_q : s_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= ModeAdd;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      s_q         <= '0;
      t_q         <= '0;
      idx_q       <= '0;
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      ba_q        <= 1'b0;
      bb_q        <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          // busy_q is still high during the done cycle, which blocks acceptance there.
          busy_q <= bus.start & ~busy_q;
          if (bus.start && !busy_q) begin
            mode_q  <= mode_e'(bus.mode);
            a_q     <= bus.operand_a;
            b_q     <= bus.operand_b;
            p_q     <= bus.modulus;
            idx_q   <= '0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            ba_q    <= 1'b0;
            bb_q    <= 1'b0;
            state_q <= StPass1;
          end
        end
        StPass1: begin
          s_q[base +: LIMB] <= main_sum;
          c1_q  <= main_cout;
          ba_q  <= ba_cout;
          bb_q  <= bb_cout;
          idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
          if (idx_q == LastIdx) state_q <= StPass2;
        end
        StPass2: begin
          t_q[base +: LIMB] <= corr_sum;
          c2_q  <= corr_cout;
          idx_q <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
          if (idx_q == LastIdx) state_q <= StDone;
        end
        StDone: begin
          result_q    <= res_sel;
          carry_out_q <= ~mod_mode & ~err_sel & c1_q;
          error_q     <= err_sel;
          done_q      <= 1'b1;
          mode_q      <= ModeAdd;
          a_q         <= '0;
          b_q         <= '0;
          p_q         <= '0;
          s_q         <= '0;
          t_q         <= '0;
          idx_q       <= '0;
          c1_q        <= 1'b0;
          c2_q        <= 1'b0;
          ba_q        <= 1'b0;
          bb_q        <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mithril_modarith_ct.sv
module tb_mithril_modarith_ct;
  import mithril_modarith_ct_pkg::*;

  localparam int unsigned W       = 256;
  localparam int unsigned Latency = 9;

  localparam logic [W-1:0] Ones = {W{1'b1}};
  localparam logic [W-1:0] P    = (256'd1 << 255) - 256'd19;
  localparam logic [W-1:0] Pm1  = (256'd1 << 255) - 256'd20;
  localparam logic [W-1:0] A1   = {32{8'h11}};
  localparam logic [W-1:0] B1   = {32{8'h22}};
  localparam logic [W-1:0] A2   = {32{8'haa}};
  localparam logic [W-1:0] B2   = {32{8'h55}};

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         co;
    logic         err;
    int unsigned  start_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        exp_q[$];

  mithril_modarith_ct_if #(.WIDTH(W)) bus ();

  mithril_modarith_ct #(.WIDTH(W), .LIMB(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks data and latency.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 want no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp({e.name, ".result"}, bus.result, e.res);
        cmp({e.name, ".carry"}, W'(bus.carry_out), W'(e.co));
        cmp({e.name, ".error"}, W'(bus.error), W'(e.err));
        cmp({e.name, ".latency"}, W'(cyc - e.start_edge), W'(Latency));
      end
    end
  end

  // Pulse start for one cycle; operands are scrambled afterwards to prove they were latched.
  task automatic issue(input string name, input mode_e m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] p, input logic [W-1:0] er,
                       input logic ec, input logic ee, input bit expect_it);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.modulus   = p;
    if (expect_it) begin
      e.name = name; e.res = er; e.co = ec; e.err = ee; e.start_edge = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_a = ~a;
    bus.operand_b = ~b;
    bus.modulus   = ~p;
    bus.mode      = ~m;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: got no done want done within 30 cycles", name);
    end
    @(negedge clk);
    cmp({name, ".busy_after"}, W'(bus.busy), W'(0));
  endtask

  task automatic run(input string name, input mode_e m, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] p, input logic [W-1:0] er,
                     input logic ec, input logic ee);
    issue(name, m, a, b, p, er, ec, ee, 1'b1);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.modulus = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("reset.result", bus.result, '0);
    cmp("reset.carry", W'(bus.carry_out), W'(0));
    cmp("reset.done", W'(bus.done), W'(0));
    cmp("reset.error", W'(bus.error), W'(0));
    cmp("reset.busy", W'(bus.busy), W'(0));

    run("add_wrap", ModeAdd, Ones, 256'd1, '0, '0, 1'b1, 1'b0);
    run("sub_0m1", ModeSub, '0, 256'd1, '0, Ones, 1'b1, 1'b0);
    run("sub_5m3", ModeSub, 256'd5, 256'd3, '0, 256'd2, 1'b0, 1'b0);
    run("madd_wrap", ModeModadd, Pm1, 256'd2, P, 256'd1, 1'b0, 1'b0);
    run("madd_nowrap", ModeModadd, Pm1, '0, P, Pm1, 1'b0, 1'b0);
    run("msub_0m1", ModeModsub, '0, 256'd1, P, Pm1, 1'b0, 1'b0);
    run("madd_a_eq_p", ModeModadd, P, '0, P, '0, 1'b0, 1'b1);
    run("madd_p_zero", ModeModadd, 256'd5, 256'd3, '0, '0, 1'b0, 1'b1);

    // 11../22.. patterns: both operands below p.
    run("pat1_add", ModeAdd, A1, B1, P, {32{8'h33}}, 1'b0, 1'b0);
    run("pat1_sub", ModeSub, A1, B1, P, ~A1 + 256'd1, 1'b1, 1'b0);
    run("pat1_madd", ModeModadd, A1, B1, P, {32{8'h33}}, 1'b0, 1'b0);
    run("pat1_msub", ModeModsub, A1, B1, P, P - A1, 1'b0, 1'b0);
    // AA../55.. patterns: a >= p, so modular modes flag an error at the same latency.
    run("pat2_add", ModeAdd, A2, B2, P, Ones, 1'b0, 1'b0);
    run("pat2_sub", ModeSub, A2, B2, P, B2, 1'b0, 1'b0);
    run("pat2_madd", ModeModadd, A2, B2, P, '0, 1'b0, 1'b1);
    run("pat2_msub", ModeModsub, A2, B2, P, '0, 1'b0, 1'b1);

    // A start pulse mid-operation must neither queue nor disturb the latched operands.
    issue("ignore_mid", ModeAdd, A1, B1, '0, {32{8'h33}}, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.mode = ModeSub;
    bus.operand_a = A2;
    bus.operand_b = B2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_mid");
    repeat (12) @(negedge clk);

    // Reset at the fourth edge after acceptance: no done, outputs cleared.
    issue("abort", ModeSub, A2, B2, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("abort.result", bus.result, '0);
    cmp("abort.carry", W'(bus.carry_out), W'(0));
    cmp("abort.error", W'(bus.error), W'(0));
    cmp("abort.busy", W'(bus.busy), W'(0));
    cmp("abort.done", W'(bus.done), W'(0));
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    run("after_abort", ModeSub, 256'd5, 256'd3, '0, 256'd2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    cmp("queue_empty", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mithril_modarith_ct.md
Name: mithril_modarith_ct

Overview:
- Parametrised, constant-time, limb-serial add/sub engine.
- Supports plain ADD/SUB and modular MODADD/MODSUB against a runtime modulus.
- Next generation of mithril_add_secure; feeds the Mithril scalar/field datapath.
- Latency is fixed by parameters only, independent of operand values, mode and error status. Operand and intermediate state is wiped on completion.

Parameters:
- WIDTH, 256, operand/result width in bits.
- LIMB, 64, bits processed per cycle; WIDTH % LIMB must be 0 (elaboration-time $error otherwise).
- NLIMB, WIDTH/LIMB, derived localparam, not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  request; accepted only when busy=0
- mode  in  2  00 ADD, 01 SUB, 10 MODADD, 11 MODSUB; latched with start
- operand_a  in  WIDTH  latched with start
- operand_b  in  WIDTH  latched with start
- modulus  in  WIDTH  latched with start; ignored in ADD/SUB
- result  out  WIDTH  registered result, valid when done=1, held until next done
- carry_out  out  1  ADD carry / SUB borrow; 0 in modular modes
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; held until next done
- busy  out  1  high from acceptance through the done cycle

Behaviour:
- Interface: one clock domain (clk); reset is synchronous and active-low (rst_n).
- Reset: result=0, carry_out=0, done=0, error=0, busy=0, FSM=IDLE, all internal registers=0.
- FSM states:
  - IDLE: start=1 latches mode/operands/modulus, clears limb index and carries -> PASS1.
  - PASS1: NLIMB cycles, one limb per cycle, LSB limb first.
    - s = a±b, chain c1 (ADD/MODADD add; SUB/MODSUB subtract).
    - In parallel: borrow chains a-p (ba) and b-p (bb).
  - PASS2: NLIMB cycles.
    - MODADD: t = s-p, borrow chain b2.
    - MODSUB: t = s+p.
    - Also executed, with results discarded, for ADD/SUB so timing is constant.
  - DONE: one cycle; registers outputs, pulses done, zeroes operand/s/t/carry registers -> IDLE.
- Latency: start sampled at edge E0; done=1 during the cycle after edge E(2*NLIMB+1). Default NLIMB=4 gives done 9 cycles after start. Next start is accepted in the cycle after done.
- Result selection (mux only, no data-dependent branching or early exit):
  - ADD/SUB: s, carry_out=c1.
  - MODADD: (c1 | ~b2) ? t : s.
  - MODSUB: c1 ? t : s.
- Error (modular modes only): modulus==0, or ba==0 (a>=p), or bb==0 (b>=p).
  - On error: result=0, carry_out=0, error=1, done still at the fixed cycle.
- start while busy=1: ignored, no queueing; latched values unchanged.
- rst_n=0 mid-operation: abort at that edge, no done pulse, all state wiped, IDLE.
- Arithmetic: all chains are LIMB+1 bit per step; carries registered between limbs; wrap modulo 2^WIDTH.

Decomposition:
- Package mithril_pkg:
  - mode encoding constants (MODE_ADD, MODE_SUB, MODE_MODADD, MODE_MODSUB)
  - FSM state encoding (IDLE, PASS1, PASS2, DONE)
  - default WIDTH/LIMB
- Sub-module mithril_limb_addsub:
  - Combinational LIMB-bit add/sub with carry/borrow in and out, sub select.
  - Instantiated four times: main, correction, a-p check, b-p check.

Test Plan:
- ADD, a=FF..FF, b=1 -> result=0, carry_out=1, error=0, done 9 cycles after start.
- SUB, a=0, b=1 -> result=FF..FF, carry_out=1; a=5, b=3 -> result=2, carry_out=0.
- MODADD, p=2^255-19:
  - a=p-1, b=2 -> result=1.
  - a=p-1, b=0 -> result=p-1 (7FF..FEC).
- MODSUB, p=2^255-19, a=0, b=1 -> result=p-1=7FFF..FFEC, carry_out=0.
- Error cases, each -> error=1, result=0, done still at cycle 9:
  - MODADD with a=p.
  - MODADD with modulus=0.
- Timing and control:
  - All modes, with 11..11/22..22 and AA..AA/55..55 patterns, give identical done latency.
  - start pulsed mid-operation is ignored.
  - rst_n low at cycle 4 -> no done, outputs 0, new start accepted normally afterwards.
